// File: rtl/cpuc_package.sv
// Shared CPUC definitions: datapath width, demux FIFO depth and the select encoding.
package cpuc_package;

  localparam int DATA_WIDTH       = 32;
  localparam int CPUC_DEMUX_DEPTH = 2;
  localparam int CPUC_DEMUX_CNT_W = 16;

  typedef enum logic {
    DEMUX_OUT0 = 1'b0,
    DEMUX_OUT1 = 1'b1
  } t_demux_sel;

endpackage

// File: rtl/cpuc_demux_fifo.sv
// Synchronous FIFO with push/pop/full/empty and a registered head entry.
// Push is ignored when full and pop is ignored when empty.
module cpuc_demux_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // NOTE: storage has no reset; the cleared count already marks every entry
  // invalid, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cpuc_demux_buf.sv
// Buffered 1-to-2 stream demultiplexer: each accepted word is queued into the
// output FIFO picked by in_sel. Define CPUC_DEMUX_CNT_EN to enable cnt0/cnt1.
module cpuc_demux_buf
  import cpuc_package::*;
#(
  parameter int DATA_WIDTH = cpuc_package::DATA_WIDTH,
  parameter int FIFO_DEPTH = CPUC_DEMUX_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sel,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        out0_valid,
  input  logic                        out0_ready,
  output logic [DATA_WIDTH-1:0]       out0_data,
  output logic                        out1_valid,
  input  logic                        out1_ready,
  output logic [DATA_WIDTH-1:0]       out1_data,
  output logic [CPUC_DEMUX_CNT_W-1:0] cnt0,
  output logic [CPUC_DEMUX_CNT_W-1:0] cnt1
);

  t_demux_sel sel;
  logic       full0, full1;
  logic       empty0, empty1;
  logic       in_fire;
  logic       push0, push1;
  logic       pop0, pop1;

  assign sel = t_demux_sel'(in_sel);

  // Ready looks only at the addressed FIFO, so one stalled consumer never
  // blocks traffic bound for the other.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through it can infer a latch.
  always_comb begin
    in_ready = 1'b0;
    unique case (sel)
      DEMUX_OUT0: in_ready = !full0;
      DEMUX_OUT1: in_ready = !full1;
    endcase
  end

  assign in_fire = in_valid && in_ready;
  assign push0   = in_fire && (sel == DEMUX_OUT0);
  assign push1   = in_fire && (sel == DEMUX_OUT1);

  // Valids are masked during reset so no output transfer happens in that cycle.
  assign out0_valid = !empty0 && !rst;
  assign out1_valid = !empty1 && !rst;
  assign pop0       = out0_valid && out0_ready;
  assign pop1       = out1_valid && out1_ready;

  cpuc_demux_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (in_data),
    .pop       (pop0),
    .full      (full0),
    .empty     (empty0),
    .head      (out0_data)
  );

  cpuc_demux_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (in_data),
    .pop       (pop1),
    .full      (full1),
    .empty     (empty1),
    .head      (out1_data)
  );

`ifdef CPUC_DEMUX_CNT_EN
  logic [CPUC_DEMUX_CNT_W-1:0] cnt0_q;
  logic [CPUC_DEMUX_CNT_W-1:0] cnt1_q;

  // Free-running wrap-around counts of accepted words per destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (push0) cnt0_q <= cnt0_q + 1'b1;
      if (push1) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_cpuc_demux_buf.sv
// Self-checking bench for cpuc_demux_buf: a directed vector table plus
// hand-written reset, stall-count and counter-wrap sequences.
module tb_cpuc_demux_buf;
  import cpuc_package::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_sel;
  logic [DW-1:0] in_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [DW-1:0] out0_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [DW-1:0] out1_data;
  logic [15:0]   cnt0;
  logic [15:0]   cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpuc_demux_buf dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  typedef struct {
    logic          iv;
    logic          is;
    logic [DW-1:0] id;
    logic          r0;
    logic          r1;
    logic          e_rdy;
    logic          e_v0;
    logic [DW-1:0] e_d0;
    logic          e_v1;
    logic [DW-1:0] e_d1;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef CPUC_DEMUX_CNT_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  task automatic drive(input logic iv, input logic is, input logic [DW-1:0] id,
                       input logic r0, input logic r1);
    in_valid   = iv;
    in_sel     = is;
    in_data    = id;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int m_cnt0;
  int m_cnt1;
  int stalls;

  initial begin
    // iv is id            r0 r1  rdy v0 d0            v1 d1
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h5A5A5A5A};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h1,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h2,        1'b0, 1'b1, 1'b1, 1'b1, 32'h1,        1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h3,        1'b0, 1'b1, 1'b0, 1'b1, 32'h1,        1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 32'h77,       1'b0, 1'b0, 1'b1, 1'b1, 32'h1,        1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h3,        1'b1, 1'b1, 1'b0, 1'b1, 32'h1,        1'b1, 32'h77};
    vecs[10] = '{1'b1, 1'b0, 32'h3,        1'b1, 1'b1, 1'b1, 1'b1, 32'h2,        1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h3,        1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 32'h11,       1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 32'h22,       1'b1, 1'b1, 1'b1, 1'b1, 32'h11,       1'b0, 32'h0};
    vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h22,       1'b0, 32'h0};
    vecs[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h22,       1'b0, 32'h0};
    vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};

    do_reset();

    // Reset state, probing ready for both destinations.
    #2;
    check("rst out0_valid", out0_valid, 1'b0);
    check("rst out1_valid", out1_valid, 1'b0);
    check("rst in_ready sel0", in_ready, 1'b1);
    in_sel = 1'b1;
    #1;
    check("rst in_ready sel1", in_ready, 1'b1);
    check("rst cnt0", cnt0, 16'h0);
    check("rst cnt1", cnt1, 16'h0);
    step();

    m_cnt0 = 0;
    m_cnt1 = 0;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].iv, vecs[i].is, vecs[i].id, vecs[i].r0, vecs[i].r1);
      #2;
      check($sformatf("v%0d in_ready", i), in_ready, vecs[i].e_rdy);
      check($sformatf("v%0d out0_valid", i), out0_valid, vecs[i].e_v0);
      check($sformatf("v%0d out1_valid", i), out1_valid, vecs[i].e_v1);
      if (vecs[i].e_v0) check($sformatf("v%0d out0_data", i), out0_data, vecs[i].e_d0);
      if (vecs[i].e_v1) check($sformatf("v%0d out1_data", i), out1_data, vecs[i].e_d1);
      check($sformatf("v%0d cnt0", i), cnt0, exp_cnt(m_cnt0));
      check($sformatf("v%0d cnt1", i), cnt1, exp_cnt(m_cnt1));
      if (vecs[i].iv && vecs[i].e_rdy) begin
        if (vecs[i].is) m_cnt1++;
        else            m_cnt0++;
      end
      step();
    end

    // Fill both FIFOs with consumers stalled, then reset mid-operation.
    drive(1'b1, 1'b0, 32'hDEAD0001, 1'b0, 1'b0); step();
    drive(1'b1, 1'b0, 32'hDEAD0002, 1'b0, 1'b0); step();
    drive(1'b1, 1'b1, 32'hDEAD0003, 1'b0, 1'b0); step();
    drive(1'b1, 1'b1, 32'hDEAD0004, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #2;
    check("full in_ready sel0", in_ready, 1'b0);
    check("full out0_data", out0_data, 32'hDEAD0001);
    in_sel = 1'b1;
    #1;
    check("full in_ready sel1", in_ready, 1'b0);
    check("full out1_data", out1_data, 32'hDEAD0003);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    check("postrst out0_valid", out0_valid, 1'b0);
    check("postrst out1_valid", out1_valid, 1'b0);
    check("postrst in_ready sel1", in_ready, 1'b1);
    in_sel = 1'b0;
    #1;
    check("postrst in_ready sel0", in_ready, 1'b1);
    check("postrst cnt0", cnt0, 16'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
      #2;
      check($sformatf("drained%0d out0_valid", i), out0_valid, 1'b0);
      check($sformatf("drained%0d out1_valid", i), out1_valid, 1'b0);
      step();
    end
    drive(1'b1, 1'b1, 32'h0000C0DE, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #2;
    check("fresh out1_valid", out1_valid, 1'b1);
    check("fresh out1_data", out1_data, 32'h0000C0DE);
    check("fresh out0_valid", out0_valid, 1'b0);

    // Stalled in_valid cycles must not count.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #2;
    check("stall cnt0", cnt0, exp_cnt(2));
    check("stall cnt1", cnt1, exp_cnt(0));

    // 65537 sel0 transfers at full rate wrap cnt0 to 1.
    do_reset();
    stalls = 0;
    for (int i = 0; i < 65537; i++) begin
      drive(1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
      #1;
      if (!in_ready) stalls++;
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    #2;
    check("wrap stalls", 64'(stalls), 64'd0);
    check("wrap cnt0", cnt0, exp_cnt(65537));
    check("wrap cnt1", cnt1, exp_cnt(0));
    check("wrap last out0_data", out0_data, 32'd65536);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
